// File: rtl/game_pkg.sv
// Shared types and helpers for the game-flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAYING,
    ST_HIT_PAUSE,
    ST_WIN,
    ST_LOSE
  } game_state_t;

  localparam logic [15:0] SCORE_MAX = 16'h9990;

  // Adds ten points to a four-digit BCD score; the units digit is always 0.
  function automatic logic [15:0] bcd_add10(input logic [15:0] s);
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    d3 = s[15:12];
    d2 = s[11:8];
    d1 = s[7:4];
    if (s >= SCORE_MAX) begin
      return SCORE_MAX;
    end
    if (d1 == 4'd9) begin
      d1 = 4'd0;
      if (d2 == 4'd9) begin
        d2 = 4'd0;
        d3 = d3 + 4'd1;
      end else begin
        d2 = d2 + 4'd1;
      end
    end else begin
      d1 = d1 + 4'd1;
    end
    return {d3, d2, d1, 4'h0};
  endfunction

endpackage

// File: rtl/game_outcome_fsm_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button, followed by a rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_async,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/game_outcome_fsm.sv
// Round sequencer: alien/life/score bookkeeping and win/lose banner timing.
//   state        | meaning
//   ST_IDLE      | waiting for start, last score shown
//   ST_PLAYING   | round in progress
//   ST_HIT_PAUSE | player hit, sprites frozen for PAUSE_FRAMES
//   ST_WIN       | all aliens destroyed, winner banner for BANNER_FRAMES
//   ST_LOSE      | lives gone or aliens landed, loser banner for BANNER_FRAMES
module game_outcome_fsm
  import game_pkg::*;
#(
  parameter int NUM_ALIENS    = 55,
  parameter int NUM_LIVES     = 3,
  parameter int PAUSE_FRAMES  = 60,
  parameter int BANNER_FRAMES = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        frame_tick,
  input  logic        alien_hit,
  input  logic        player_hit,
  input  logic        invaders_landed,
  output logic        winner,
  output logic        loser,
  output logic        playing,
  output logic        freeze,
  output logic [1:0]  lives_left,
  output logic [5:0]  aliens_left,
  output logic [15:0] score
);

  localparam int FRAME_MAX = (PAUSE_FRAMES > BANNER_FRAMES) ? PAUSE_FRAMES : BANNER_FRAMES;
  localparam int FW        = $clog2(FRAME_MAX + 1);

  localparam logic [FW-1:0] PAUSE_LAST  = FW'(PAUSE_FRAMES - 1);
  localparam logic [FW-1:0] BANNER_LAST = FW'(BANNER_FRAMES - 1);
  localparam logic [5:0]    ALIENS_INIT = 6'(NUM_ALIENS);
  localparam logic [1:0]    LIVES_INIT  = 2'(NUM_LIVES);

  logic start_pulse;

  btn_sync_edge u_start_sync (
    .clk       (clk),
    .rst       (rst),
    .btn_async (start_btn),
    .pulse     (start_pulse)
  );

  game_state_t   state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]    lives_q, lives_d;
  logic [5:0]    aliens_q, aliens_d;
  logic [15:0]   score_q, score_d;
  logic          winner_q, winner_d;
  logic          loser_q, loser_d;
  logic          playing_q, playing_d;
  logic          freeze_q, freeze_d;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    lives_d     = lives_q;
    aliens_d    = aliens_q;
    score_d     = score_q;

    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          lives_d  = LIVES_INIT;
          aliens_d = ALIENS_INIT;
          score_d  = 16'h0000;
          state_d  = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (invaders_landed) begin
          state_d = ST_LOSE;
        end else begin
          if (alien_hit) begin
            if (aliens_q != 6'd0) aliens_d = aliens_q - 6'd1;
            score_d = bcd_add10(score_q);
          end
          // Clearing the last alien wins even if the player is struck in the same cycle.
          if (alien_hit && aliens_q == 6'd1) begin
            state_d = ST_WIN;
          end else if (player_hit) begin
            if (lives_q <= 2'd1) begin
              lives_d = 2'd0;
              state_d = ST_LOSE;
            end else begin
              lives_d = lives_q - 2'd1;
              state_d = ST_HIT_PAUSE;
            end
          end
        end
      end
      ST_HIT_PAUSE: begin
        if (invaders_landed) begin
          state_d = ST_LOSE;
        end else if (frame_tick) begin
          if (frame_cnt_q == PAUSE_LAST) state_d = ST_PLAYING;
          else frame_cnt_d = frame_cnt_q + FW'(1);
        end
      end
      ST_WIN, ST_LOSE: begin
        if (frame_tick) begin
          if (frame_cnt_q == BANNER_LAST) state_d = ST_IDLE;
          else frame_cnt_d = frame_cnt_q + FW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) frame_cnt_d = '0;

    winner_d  = (state_d == ST_WIN);
    loser_d   = (state_d == ST_LOSE);
    playing_d = (state_d == ST_PLAYING) || (state_d == ST_HIT_PAUSE);
    freeze_d  = (state_d == ST_HIT_PAUSE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      lives_q     <= LIVES_INIT;
      aliens_q    <= ALIENS_INIT;
      score_q     <= 16'h0000;
      winner_q    <= 1'b0;
      loser_q     <= 1'b0;
      playing_q   <= 1'b0;
      freeze_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      lives_q     <= lives_d;
      aliens_q    <= aliens_d;
      score_q     <= score_d;
      winner_q    <= winner_d;
      loser_q     <= loser_d;
      playing_q   <= playing_d;
      freeze_q    <= freeze_d;
    end
  end

  assign winner      = winner_q;
  assign loser       = loser_q;
  assign playing     = playing_q;
  assign freeze      = freeze_q;
  assign lives_left  = lives_q;
  assign aliens_left = aliens_q;
  assign score       = score_q;

endmodule

// File: tb/tb_game_outcome_fsm.sv
// Bench for game_outcome_fsm: directed scenarios plus random play against a points-based model.
module tb_game_outcome_fsm;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_WIN   = 3;
  localparam int M_LOSE  = 4;

  localparam logic [27:0] RESET_VEC = {4'b0000, 2'd3, 6'd55, 16'h0000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_btn = 1'b0;
  logic        frame_tick = 1'b0;
  logic        alien_hit = 1'b0;
  logic        player_hit = 1'b0;
  logic        invaders_landed = 1'b0;
  logic        winner, loser, playing, freeze;
  logic [1:0]  lives_left;
  logic [5:0]  aliens_left;
  logic [15:0] score;
  logic [27:0] dut_vec;

  int total = 0;
  int bad   = 0;

  int m_mode, m_lives, m_aliens, m_pts, m_frames;
  bit h1, h2, h3;

  game_outcome_fsm dut (
    .clk             (clk),
    .rst             (rst),
    .start_btn       (start_btn),
    .frame_tick      (frame_tick),
    .alien_hit       (alien_hit),
    .player_hit      (player_hit),
    .invaders_landed (invaders_landed),
    .winner          (winner),
    .loser           (loser),
    .playing         (playing),
    .freeze          (freeze),
    .lives_left      (lives_left),
    .aliens_left     (aliens_left),
    .score           (score)
  );

  always #5 clk = ~clk;

  assign dut_vec = {winner, loser, playing, freeze, lives_left, aliens_left, score};

  function automatic logic [27:0] exp_vec();
    logic [15:0] s;
    s = {4'(m_pts / 1000), 4'((m_pts / 100) % 10), 4'((m_pts / 10) % 10), 4'(m_pts % 10)};
    return {m_mode == M_WIN, m_mode == M_LOSE, (m_mode == M_PLAY) || (m_mode == M_PAUSE),
            m_mode == M_PAUSE, 2'(m_lives), 6'(m_aliens), s};
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_lives = 3; m_aliens = 55; m_pts = 0; m_frames = 0;
    h1 = 0; h2 = 0; h3 = 0;
  endfunction

  // One clock edge of the game rules, seen from the player's side.
  function automatic void model_step();
    int old;
    bit pulse;
    pulse = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = start_btn;
    old = m_mode;
    case (m_mode)
      M_IDLE: if (pulse) begin
        m_lives = 3; m_aliens = 55; m_pts = 0; m_mode = M_PLAY;
      end
      M_PLAY: begin
        if (invaders_landed) m_mode = M_LOSE;
        else begin
          if (alien_hit) begin
            if (m_aliens > 0) m_aliens--;
            m_pts = (m_pts + 10 > 9990) ? 9990 : m_pts + 10;
            if (m_aliens == 0) m_mode = M_WIN;
          end
          if (m_mode == M_PLAY && player_hit) begin
            m_lives--;
            m_mode = (m_lives == 0) ? M_LOSE : M_PAUSE;
          end
        end
      end
      M_PAUSE: begin
        if (invaders_landed) m_mode = M_LOSE;
        else if (frame_tick) begin
          m_frames++;
          if (m_frames == 60) m_mode = M_PLAY;
        end
      end
      default: if (frame_tick) begin
        m_frames++;
        if (m_frames == 600) m_mode = M_IDLE;
      end
    endcase
    if (m_mode != old) m_frames = 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    frame_tick = 0; alien_hit = 0; player_hit = 0; invaders_landed = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); start_btn = 0;
    #12;
    model_reset();
    total++;
    if (dut_vec !== RESET_VEC) begin
      bad++; $display("FAIL reset_values: got=%h want=%h", dut_vec, RESET_VEC);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_start_timing();
    for (int i = 0; i < 9; i++) cyc();
    start_btn = 1;
    cyc();
    cyc();
    total++;
    if (dut_vec !== RESET_VEC || dut_vec !== exp_vec()) begin
      bad++; $display("FAIL start_edge11: got=%h want=%h", dut_vec, RESET_VEC);
    end
    cyc();
    total++;
    if (dut_vec !== {4'b0010, 2'd3, 6'd55, 16'h0000} || dut_vec !== exp_vec()) begin
      bad++; $display("FAIL start_edge12: got=%h want=%h", dut_vec, {4'b0010, 2'd3, 6'd55, 16'h0000});
    end
    start_btn = 0;
    cyc();
  endtask

  task automatic test_win();
    for (int i = 0; i < 55; i++) begin
      alien_hit = 1; player_hit = (i == 54); frame_tick = 1'($urandom_range(0, 1));
      cyc();
      clear_inputs();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL win_hits[%0d]: got=%h want=%h", i, dut_vec, exp_vec());
      end
      if (i != 54) repeat ($urandom_range(0, 2)) cyc();
    end
    total++;
    if (dut_vec !== {4'b1000, 2'd3, 6'd0, 16'h0550}) begin
      bad++; $display("FAIL win_reached: got=%h want=%h", dut_vec, {4'b1000, 2'd3, 6'd0, 16'h0550});
    end
    for (int k = 1; k <= 600; k++) begin
      alien_hit = 1'($urandom_range(0, 1)); invaders_landed = 1'($urandom_range(0, 1));
      cyc();
      frame_tick = 1;
      cyc();
      clear_inputs();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL win_banner[%0d]: got=%h want=%h", k, dut_vec, exp_vec());
      end
    end
    total++;
    if (dut_vec !== {4'b0000, 2'd3, 6'd0, 16'h0550}) begin
      bad++; $display("FAIL win_to_idle: got=%h want=%h", dut_vec, {4'b0000, 2'd3, 6'd0, 16'h0550});
    end
  endtask

  task automatic press_start();
    start_btn = 1; cyc(); start_btn = 0;
    repeat (3) cyc();
  endtask

  task automatic run_pause(input string tag);
    for (int k = 1; k <= 60; k++) begin
      alien_hit = 1'($urandom_range(0, 1)); player_hit = 1'($urandom_range(0, 1));
      cyc();
      frame_tick = 1;
      cyc();
      clear_inputs();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL %s[%0d]: got=%h want=%h", tag, k, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_pause();
    press_start();
    player_hit = 1; cyc(); clear_inputs();
    total++;
    if (dut_vec !== {4'b0011, 2'd2, 6'd55, 16'h0000}) begin
      bad++; $display("FAIL pause_enter: got=%h want=%h", dut_vec, {4'b0011, 2'd2, 6'd55, 16'h0000});
    end
    run_pause("pause_tick");
    total++;
    if (dut_vec !== {4'b0010, 2'd2, 6'd55, 16'h0000}) begin
      bad++; $display("FAIL pause_exit: got=%h want=%h", dut_vec, {4'b0010, 2'd2, 6'd55, 16'h0000});
    end
  endtask

  task automatic test_lose_lives();
    player_hit = 1; cyc(); clear_inputs();
    run_pause("lose_pause");
    player_hit = 1; cyc(); clear_inputs();
    total++;
    if (dut_vec !== {4'b0100, 2'd0, 6'd55, 16'h0000}) begin
      bad++; $display("FAIL lose_lives: got=%h want=%h", dut_vec, {4'b0100, 2'd0, 6'd55, 16'h0000});
    end
    start_btn = 1; repeat (3) cyc(); start_btn = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (dut_vec !== {4'b0100, 2'd0, 6'd55, 16'h0000} || dut_vec !== exp_vec()) begin
        bad++; $display("FAIL lose_ignores_start[%0d]: got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    frame_tick = 1; repeat (600) cyc(); clear_inputs();
    total++;
    if (dut_vec !== {4'b0000, 2'd0, 6'd55, 16'h0000}) begin
      bad++; $display("FAIL lose_to_idle: got=%h want=%h", dut_vec, {4'b0000, 2'd0, 6'd55, 16'h0000});
    end
  endtask

  task automatic test_landed_in_pause();
    press_start();
    player_hit = 1; cyc(); clear_inputs();
    repeat (2) cyc();
    invaders_landed = 1; cyc(); clear_inputs();
    total++;
    if (dut_vec !== {4'b0100, 2'd2, 6'd55, 16'h0000}) begin
      bad++; $display("FAIL landed_in_pause: got=%h want=%h", dut_vec, {4'b0100, 2'd2, 6'd55, 16'h0000});
    end
    frame_tick = 1; repeat (600) cyc(); clear_inputs();
    total++;
    if (dut_vec !== exp_vec()) begin
      bad++; $display("FAIL landed_to_idle: got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6000; i++) begin
      alien_hit       = ($urandom_range(0, 5) == 0);
      player_hit      = ($urandom_range(0, 59) == 0);
      invaders_landed = ($urandom_range(0, 799) == 0);
      frame_tick      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) start_btn = ~start_btn;
      cyc();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL random[%0d]: got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    clear_inputs();
    start_btn = 0;
    frame_tick = 1; repeat (700) cyc(); clear_inputs();
    repeat (4) cyc();
  endtask

  task automatic test_reset_mid_win();
    press_start();
    alien_hit = 1; repeat (55) cyc(); clear_inputs();
    frame_tick = 1; repeat (50) cyc(); clear_inputs();
    total++;
    if (winner !== 1'b1 || dut_vec !== exp_vec()) begin
      bad++; $display("FAIL mid_win_before_rst: got=%h want=%h", dut_vec, exp_vec());
    end
    #3;
    rst = 1;
    start_btn = 1;
    #1;
    model_reset();
    total++;
    if (dut_vec !== RESET_VEC) begin
      bad++; $display("FAIL rst_mid_win: got=%h want=%h", dut_vec, RESET_VEC);
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL held_start[%0d]: got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    total++;
    if (dut_vec !== {4'b0010, 2'd3, 6'd55, 16'h0000}) begin
      bad++; $display("FAIL held_start_play: got=%h want=%h", dut_vec, {4'b0010, 2'd3, 6'd55, 16'h0000});
    end
    invaders_landed = 1; cyc(); clear_inputs();
    frame_tick = 1; repeat (600) cyc(); clear_inputs();
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++;
      if (dut_vec !== {4'b0000, 2'd3, 6'd55, 16'h0000} || dut_vec !== exp_vec()) begin
        bad++; $display("FAIL single_start[%0d]: got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
    start_btn = 0;
  endtask

  initial begin
    test_reset();
    test_start_timing();
    test_win();
    test_pause();
    test_lose_lives();
    test_landed_in_pause();
    test_random();
    test_reset_mid_win();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
